// File: rtl/cp_if.sv
// Handshake and datapath-control bundle between the encoder sequencer,
// the column-parity controller and the column-parity datapath.
interface cp_if #(
    parameter int unsigned ADDR_W = 6
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] wr_addr;
    logic              mem_wr;
    logic              rst1;
    logic              ld1;
    logic              shift;
    logic              rst2;
    logic              ld2;
    logic              rst3;
    logic              ld3;
    logic              id_rst;
    logic              inc_i;
    logic              dp_done;

    modport master (
        input  start, dp_done,
        output busy, done, err, rd_addr, mem_rd, wr_addr, mem_wr,
               rst1, ld1, shift, rst2, ld2, rst3, ld3, id_rst, inc_i
    );

    modport slave (
        output start, dp_done,
        input  busy, done, err, rd_addr, mem_rd, wr_addr, mem_wr,
               rst1, ld1, shift, rst2, ld2, rst3, ld3, id_rst, inc_i
    );
endinterface

// File: rtl/cp_controller.sv
// Sequences the column-parity datapath over all slices of one state:
// primes prev-parity with the last slice, then load/parity/shift/write per slice.
module cp_controller #(
    parameter int unsigned NUM_SLICES = 64,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic clk,
    input  logic rst,
    cp_if.master bus
);
    localparam int unsigned SC_W = 5;
    localparam logic [ADDR_W-1:0] LAST_K  = ADDR_W'(NUM_SLICES - 1);
    localparam logic [SC_W-1:0]   SC_LAST = SC_W'(24);

    typedef enum logic [3:0] {
        IDLE, INIT, PRIME_LD, PRIME_PAR, LOAD, PARITY, SHIFT, WRITE, FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic              err_q, err_d;

    logic              busy_q, done_q, mem_rd_q, mem_wr_q;
    logic              rst1_q, ld1_q, shift_q, rst2_q, ld2_q, rst3_q, ld3_q;
    logic              id_rst_q, inc_i_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;

    logic              busy_d, done_d, mem_rd_d, mem_wr_d;
    logic              rst1_d, ld1_d, shift_d, rst2_d, ld2_d, rst3_d, ld3_d;
    logic              id_rst_d, inc_i_d;
    logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;

    // Next state, then outputs decoded from the next state so the registered
    // outputs line up cycle-for-cycle with the state register.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        sc_d      = sc_q;
        err_d     = err_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        rst1_d    = 1'b0;
        ld1_d     = 1'b0;
        shift_d   = 1'b0;
        rst2_d    = 1'b0;
        ld2_d     = 1'b0;
        rst3_d    = 1'b0;
        ld3_d     = 1'b0;
        id_rst_d  = 1'b0;
        inc_i_d   = 1'b0;
        rd_addr_d = '0;
        wr_addr_d = '0;

        unique case (state_q)
            IDLE:      if (bus.start) state_d = INIT;
            INIT: begin
                k_d     = '0;
                state_d = PRIME_LD;
            end
            PRIME_LD:  state_d = PRIME_PAR;
            PRIME_PAR: state_d = LOAD;
            LOAD:      state_d = PARITY;
            PARITY: begin
                sc_d    = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (sc_q == SC_LAST) state_d = WRITE;
                else                 sc_d    = SC_W'(sc_q + 1'b1);
            end
            WRITE: begin
                if (!bus.dp_done) err_d = 1'b1;
                if (k_q == LAST_K) begin
                    state_d = FINISH;
                end else begin
                    k_d     = ADDR_W'(k_q + 1'b1);
                    state_d = LOAD;
                end
            end
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        unique case (state_d)
            INIT: begin
                rst1_d   = 1'b1;
                rst2_d   = 1'b1;
                rst3_d   = 1'b1;
                id_rst_d = 1'b1;
            end
            PRIME_LD: begin
                rd_addr_d = LAST_K;
                mem_rd_d  = 1'b1;
                ld1_d     = 1'b1;
            end
            PRIME_PAR: ld2_d = 1'b1;
            LOAD: begin
                rd_addr_d = k_d;
                mem_rd_d  = 1'b1;
                ld1_d     = 1'b1;
                id_rst_d  = 1'b1;
            end
            PARITY: begin
                ld2_d = 1'b1;
                ld3_d = 1'b1;
            end
            SHIFT: begin
                shift_d = 1'b1;
                inc_i_d = 1'b1;
            end
            WRITE: begin
                wr_addr_d = k_d;
                mem_wr_d  = 1'b1;
            end
            FINISH:  done_d = 1'b1;
            default: ;
        endcase
    end

    // State and output registers; synchronous reset drops everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            sc_q      <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            rst1_q    <= 1'b0;
            ld1_q     <= 1'b0;
            shift_q   <= 1'b0;
            rst2_q    <= 1'b0;
            ld2_q     <= 1'b0;
            rst3_q    <= 1'b0;
            ld3_q     <= 1'b0;
            id_rst_q  <= 1'b0;
            inc_i_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            sc_q      <= sc_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            rst1_q    <= rst1_d;
            ld1_q     <= ld1_d;
            shift_q   <= shift_d;
            rst2_q    <= rst2_d;
            ld2_q     <= ld2_d;
            rst3_q    <= rst3_d;
            ld3_q     <= ld3_d;
            id_rst_q  <= id_rst_d;
            inc_i_q   <= inc_i_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.mem_rd  = mem_rd_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.mem_wr  = mem_wr_q;
    assign bus.rst1    = rst1_q;
    assign bus.ld1     = ld1_q;
    assign bus.shift   = shift_q;
    assign bus.rst2    = rst2_q;
    assign bus.ld2     = ld2_q;
    assign bus.rst3    = rst3_q;
    assign bus.ld3     = ld3_q;
    assign bus.id_rst  = id_rst_q;
    assign bus.inc_i   = inc_i_q;
endmodule
